// File: rtl/spi_alu_slave_if.sv
// rtl/spi_alu_slave_if.sv - shared SPI bus signals seen by one ALU slave
interface spi_alu_slave_if;
  logic nss;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output nss, output sclk, output mosi, input miso);
  modport slave  (input nss, input sclk, input mosi, output miso);
endinterface

// File: rtl/spi_alu_slave.sv
// rtl/spi_alu_slave.sv - SPI-slave ALU: receive {op, opa, opb}, return opa op opb on miso
// Optional SPI_INPUT_SYNC_EN adds 2-flop synchronizers on nss, sclk and mosi.
module spi_alu_slave #(
  parameter int WIDTH = 32
) (
  input logic            clock,
  input logic            reset,
  spi_alu_slave_if.slave bus
);
  localparam int FRAME = 3 + 2 * WIDTH;
  localparam int CW    = $clog2(FRAME + 1);

  typedef enum logic [2:0] {IDLE, RECV, CALC, SEND, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count, count_next;
  logic [FRAME-1:0] rx, rx_next;
  logic [WIDTH-1:0] tx, tx_next;
  logic             nss_s, sclk_s, mosi_s, sclk_q;
  logic             rise, fall;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] opa, opb, result;

`ifdef SPI_INPUT_SYNC_EN
  logic [1:0] nss_sync, sclk_sync, mosi_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nss_sync  <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
    end else begin
      nss_sync  <= {nss_sync[0], bus.nss};
      sclk_sync <= {sclk_sync[0], bus.sclk};
      mosi_sync <= {mosi_sync[0], bus.mosi};
    end
  end

  assign nss_s  = nss_sync[1];
  assign sclk_s = sclk_sync[1];
  assign mosi_s = mosi_sync[1];
`else
  assign nss_s  = bus.nss;
  assign sclk_s = bus.sclk;
  assign mosi_s = bus.mosi;
`endif

  assign rise = sclk_s & ~sclk_q;
  assign fall = ~sclk_s & sclk_q;

  always_comb begin
    opcode = rx[FRAME-1 -: 3];
    opa    = rx[2*WIDTH-1 -: WIDTH];
    opb    = rx[WIDTH-1:0];
    case (opcode)
      3'b000:  result = opa + opb;
      3'b001:  result = opa - opb;
      3'b010:  result = opa & opb;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      rx     <= '0;
      tx     <= '0;
      sclk_q <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      rx     <= rx_next;
      tx     <= tx_next;
      sclk_q <= sclk_s;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    rx_next    = rx;
    tx_next    = tx;
    if (state != IDLE && nss_s) begin
      state_next = IDLE;
      count_next = '0;
      rx_next    = '0;
      tx_next    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!nss_s) begin
            count_next = '0;
            state_next = RECV;
          end
        end
        RECV: begin
          if (rise) begin
            rx_next    = {rx[FRAME-2:0], mosi_s};
            count_next = count + CW'(1);
            if (count == CW'(FRAME - 1)) state_next = CALC;
          end
        end
        CALC: begin
          tx_next    = result;
          count_next = '0;
          state_next = SEND;
        end
        SEND: begin
          // The fall closing the last receive bit lands here before any
          // result bit was sampled; only shift after a counted rise.
          if (rise) begin
            count_next = count + CW'(1);
            if (count == CW'(WIDTH - 1)) state_next = DONE;
          end else if (fall && count != '0) begin
            tx_next = tx << 1;
          end
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.miso = (state == SEND) ? tx[WIDTH-1] : 1'b0;
endmodule

// File: tb/tb_spi_alu_slave.sv
// tb/tb_spi_alu_slave.sv - bench for spi_alu_slave: vector table, random frames, abort/reset cases
module tb_spi_alu_slave;
  localparam int HALF = 6;
`ifdef SPI_INPUT_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic clock;
  logic reset;
  spi_alu_slave_if bus();

  spi_alu_slave #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int total;
  int bad;
  int hyg_bad;
  int first_hi;
  int lat_seen;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned s;
    case (op)
      3'd0:    s = longint'(a) + longint'(b);
      3'd1:    s = longint'(a) + 64'h1_0000_0000 - longint'(b);
      3'd2:    s = longint'(a & b);
      default: s = 0;
    endcase
    return s[31:0] % 32'hFFFF_FFFF == s[31:0] ? s[31:0] : s[31:0];
  endfunction

  // One sclk period; returns miso as seen just before the rising edge.
  task automatic pulse(input logic b, input logic quiet, output logic s);
    bus.mosi = b;
    for (int k = 0; k < HALF; k++) begin
      @(negedge clock);
      if (quiet && bus.miso) hyg_bad++;
    end
    s = bus.miso;
    bus.sclk = 1'b1;
    first_hi = 0;
    for (int k = 1; k <= HALF; k++) begin
      @(negedge clock);
      if (quiet && bus.miso) hyg_bad++;
      if (bus.miso && first_hi == 0) first_hi = k;
    end
    bus.sclk = 1'b0;
  endtask

  task automatic shift_in(input logic [66:0] f);
    logic s;
    for (int i = 66; i >= 0; i--) pulse(f[i], i != 0, s);
    lat_seen = first_hi;
  endtask

  task automatic read_out(input int n, output logic [31:0] r);
    logic s;
    r = '0;
    for (int j = 31; j > 31 - n; j--) begin
      pulse(1'b0, 1'b0, s);
      r[j] = s;
    end
  endtask

  task automatic do_frame(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r);
    logic s;
    bus.nss = 1'b0;
    repeat (2) @(negedge clock);
    shift_in({op, a, b});
    read_out(32, r);
    pulse(1'b1, 1'b1, s);
    pulse(1'b0, 1'b1, s);
    bus.nss = 1'b1;
    repeat (3) @(negedge clock);
    if (bus.miso) hyg_bad++;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    logic        s;

    vt[0] = '{3'b000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, "add"};
    vt[1] = '{3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, "sub_wrap"};
    vt[2] = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, "add_ovf"};
    vt[3] = '{3'b010, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, "and"};
    vt[4] = '{3'b101, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, "op101"};

    total = 0;
    bad = 0;
    hyg_bad = 0;
    reset = 1'b0;
    bus.nss = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_miso", {31'b0, bus.miso}, 32'h0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_miso", {31'b0, bus.miso}, 32'h0);

    for (int i = 0; i < 5; i++) begin
      do_frame(vt[i].op, vt[i].a, vt[i].b, r);
      check(vt[i].name, r, vt[i].exp);
      if (vt[i].exp[31]) check("latency", lat_seen, LAT);
    end

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      do_frame(rop, ra, rb, r);
      check("random", r, ref_alu(rop, ra, rb));
    end
    check("hygiene_frames", hyg_bad, 0);

    // Abort after 40 bits, then sclk/mosi toggling with nss high.
    hyg_bad = 0;
    bus.nss = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < 40; i++) pulse(1'($urandom), 1'b1, s);
    bus.nss = 1'b1;
    for (int i = 0; i < 40; i++) pulse(1'($urandom), 1'b1, s);
    check("abort_quiet", hyg_bad, 0);
    do_frame(3'b000, 32'h7, 32'h8, r);
    check("after_abort", r, 32'h0000_000F);

    // Reset in the middle of SEND while miso is driving a 1.
    bus.nss = 1'b0;
    repeat (2) @(negedge clock);
    shift_in({3'b001, 32'h0, 32'h1});
    read_out(10, r);
    check("send_before_reset", {31'b0, bus.miso}, 32'h1);
    reset = 1'b0;
    #1;
    check("reset_mid_send", {31'b0, bus.miso}, 32'h0);
    repeat (2) @(negedge clock);
    bus.nss = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("post_reset_idle", {31'b0, bus.miso}, 32'h0);
    do_frame(3'b010, 32'hFFFF_0000, 32'h0F0F_F0F0, r);
    check("after_reset", r, 32'h0F0F_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
